// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, immediate
// extraction, fetch FSM encodings and the predictor counter reset value.
package icache_fetch_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Counters come out of reset weakly not-taken.
  localparam logic [1:0] BHT_RESET = 2'b01;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  // J-type immediate; only the instruction bits that carry it are passed in.
  function automatic logic [31:0] imm_j(input logic [31:12] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // B-type immediate from the upper (31:25) and lower (11:7) fields.
  function automatic logic [31:0] imm_b(input logic [31:25] hi, input logic [11:7] lo);
    return {{19{hi[31]}}, hi[31], lo[7], hi[30:25], lo[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/icache_bht.sv
// Branch history table: an array of 2-bit saturating counters with one
// combinational lookup port and one registered update port. A lookup and an
// update of the same entry in one cycle see the pre-update value.
module icache_bht
  import icache_fetch_pkg::*;
#(
  parameter int ENTRIES = 1024,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt [ENTRIES];

  // Saturating increment on taken, decrement on not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= BHT_RESET;
    end else if (rdy && upd_valid) begin
      if (upd_taken) begin
        if (cnt[upd_idx] != 2'b11) cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
      end else begin
        if (cnt[upd_idx] != 2'b00) cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
      end
    end
  end

  assign lookup_taken = cnt[lookup_idx][1];

endmodule

// File: rtl/icache_fetch.sv
// Instruction fetch stage with a set-associative I-cache (1 or 2 ways, LRU)
// and optional 2-bit branch prediction, enabled by defining
// ICACHE_PREDICT_EN. Without it the next PC is always pc+4.
//
// Refill handshake: mem_req rises with mem_addr and both hold steady until
// the controller returns a one-cycle mem_valid pulse carrying the whole
// line; mem_req drops on the following edge. mem_valid outside a refill is
// ignored. The refill always targets the latched miss address, so a
// redirect while a refill is outstanding only moves the PC.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int          SETS        = 16,
  parameter int          WAYS        = 2,
  parameter int          LINE_WORDS  = 16,
  parameter int          BHT_ENTRIES = 1024,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     stall,
  output logic [31:0]              inst,
  output logic                     inst_valid,
  output logic [31:0]              inst_pc,
  output logic                     pred_jump,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic [LINE_WORDS*32-1:0] mem_line,
  input  logic                     mem_valid,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     upd_valid,
  input  logic [31:0]              upd_pc,
  input  logic                     upd_taken,
  output logic [0:0]               dbg_state
);

  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;
  localparam int LINE_W = LINE_WORDS * 32;

  logic [31:0]       pc;
  logic [0:0]        state;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
  logic [LINE_W-1:0] data_q [WAYS][SETS];

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [WSEL_W-1:0] pc_wsel;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;

  logic              hit;
  logic              hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [WSEL_W+4:0] hit_bit;
  logic [31:0]       hit_word;
  logic              fill_way;
  logic              fill;
  logic              issue;
  logic [31:0]       next_pc;
  logic              pred_taken;

  assign pc_idx   = pc[OFF_W +: IDX_W];
  assign pc_tag   = pc[31 -: TAG_W];
  assign pc_wsel  = pc[2 +: WSEL_W];
  assign miss_idx = mem_addr[OFF_W +: IDX_W];
  assign miss_tag = mem_addr[31 -: TAG_W];

  // Tag match across the ways of the set the current PC indexes.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[pc_idx][w] && (tag_q[w][pc_idx] == pc_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
  end

  assign hit_line = data_q[hit_way][pc_idx];
  assign hit_bit  = {pc_wsel, 5'd0};
  assign hit_word = hit_line[hit_bit +: 32];

  // The LRU bit names the victim; a direct-mapped cache always fills way 0.
  assign fill_way = (WAYS == 2) ? lru_q[miss_idx] : 1'b0;
  assign fill     = (state == ST_MISS) && mem_valid;
  assign issue    = (state == ST_IDLE) && hit && !stall && !redirect_valid;

`ifdef ICACHE_PREDICT_EN
  localparam int BHT_IW = $clog2(BHT_ENTRIES);

  logic bht_taken;
  logic unused_upd_pc;

  assign unused_upd_pc = ^{upd_pc[31:2+BHT_IW], upd_pc[1:0]};

  icache_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .lookup_idx   (pc[2 +: BHT_IW]),
    .lookup_taken (bht_taken),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_pc[2 +: BHT_IW]),
    .upd_taken    (upd_taken)
  );

  // JAL always redirects; conditional branches follow the counter MSB.
  always_comb begin
    next_pc    = pc + 32'd4;
    pred_taken = 1'b0;
    if (hit_word[6:0] == OP_JAL) begin
      next_pc    = pc + imm_j(hit_word[31:12]);
      pred_taken = 1'b1;
    end else if ((hit_word[6:0] == OP_BRANCH) && bht_taken) begin
      next_pc    = pc + imm_b(hit_word[31:25], hit_word[11:7]);
      pred_taken = 1'b1;
    end
  end
`else
  logic unused_upd;

  assign unused_upd = ^{upd_valid, upd_pc, upd_taken};
  assign next_pc    = pc + 32'd4;
  assign pred_taken = 1'b0;
`endif

  // Fetch FSM: a lookup miss latches the line address and requests a
  // refill; the refill completes on mem_valid regardless of redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (!hit && !redirect_valid) begin
            state    <= ST_MISS;
            mem_req  <= 1'b1;
            mem_addr <= {pc[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
        ST_MISS: begin
          if (mem_valid) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // PC and issue registers: redirect beats stall beats issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= 32'h0;
      inst_valid <= 1'b0;
      inst_pc    <= 32'h0;
      pred_jump  <= 1'b0;
    end else if (rdy) begin
      if (redirect_valid) begin
        pc         <= redirect_pc;
        inst_valid <= 1'b0;
      end else if (issue) begin
        pc         <= next_pc;
        inst       <= hit_word;
        inst_valid <= 1'b1;
        inst_pc    <= pc;
        pred_jump  <= pred_taken;
      end else begin
        inst_valid <= 1'b0;
      end
    end
  end

  // Valid and LRU bits: a fill or an issued hit makes that way most recent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      lru_q <= '0;
    end else if (rdy) begin
      if (fill) begin
        valid_q[miss_idx][fill_way] <= 1'b1;
        lru_q[miss_idx]             <= ~fill_way;
      end else if (issue) begin
        lru_q[pc_idx] <= ~hit_way;
      end
    end
  end

  // Tag and data storage need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_q[fill_way][miss_idx]  <= miss_tag;
      data_q[fill_way][miss_idx] <= mem_line;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural fetch/cache model.
`timescale 1ns/1ps
module tb_icache_fetch;

  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rdy = 1'b1;
  logic            stall = 1'b0;
  logic [31:0]     inst;
  logic            inst_valid;
  logic [31:0]     inst_pc;
  logic            pred_jump;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [LW*32-1:0] mem_line = '0;
  logic            mem_valid = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [31:0]     redirect_pc = 32'h0;
  logic            upd_valid = 1'b0;
  logic [31:0]     upd_pc = 32'h0;
  logic            upd_taken = 1'b0;
  logic [0:0]      dbg_state;

  icache_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .stall          (stall),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .pred_jump      (pred_jump),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_line       (mem_line),
    .mem_valid      (mem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];   // {pred_jump, inst_pc, inst}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] imem [1024];
  logic [31:0] m_tag [2][16];
  bit          m_val [2][16];
  int          m_lru [16];
  int          bht   [1024];
  bit          m_miss;
  logic [31:0] m_pc, m_maddr;
  bit          e_valid, e_pred;
  logic [31:0] e_inst, e_ipc;
  bit          new_miss, new_issue;
  bit          predict_on;

  // memory controller state
  bit mc_busy, spur_en, force_spur;
  int mc_cnt, mc_lat;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return imem[a[11:2]];
  endfunction

  function automatic logic [31:0] j_off(input logic [31:0] w);
    int v;
    v = 0;
    if (w[31]) v = -(1 << 20);
    v = v + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
    return 32'(v);
  endfunction

  function automatic logic [31:0] b_off(input logic [31:0] w);
    int v;
    v = 0;
    if (w[31]) v = -(1 << 12);
    v = v + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
    return 32'(v);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin m_val[w][s] = 0; m_tag[w][s] = 0; end
    for (int s = 0; s < 16; s++) m_lru[s] = 0;
    for (int i = 0; i < 1024; i++) bht[i] = 1;
    m_miss = 0; m_pc = 32'h0; m_maddr = 32'h0;
    e_valid = 0; e_pred = 0; e_inst = 0; e_ipc = 0;
    exp_q.delete();
  endtask

  // One rising edge of the fetch stage as the rules describe it.
  task automatic model_step();
    int set, hw, fs, way, bi, ub;
    bit hit;
    logic [31:0] w, nxt;
    bit pj;
    new_miss = 0; new_issue = 0;
    if (!rdy) return;
    set = int'((m_pc >> 6) % 16);
    hit = 0; hw = 0;
    for (int k = 0; k < 2; k++)
      if (m_val[k][set] && m_tag[k][set] == (m_pc >> 10)) begin hit = 1; hw = k; end
    bi = int'((m_pc >> 2) % 1024);
    if (m_miss) begin
      if (mem_valid) begin
        fs = int'((m_maddr >> 6) % 16);
        way = m_lru[fs];
        m_val[way][fs] = 1;
        m_tag[way][fs] = m_maddr >> 10;
        m_lru[fs] = 1 - way;
        m_miss = 0;
      end
      e_valid = 0;
      if (redirect_valid) m_pc = redirect_pc;
    end else if (redirect_valid) begin
      m_pc = redirect_pc;
      e_valid = 0;
    end else if (!hit) begin
      m_miss = 1;
      m_maddr = m_pc & ~32'd63;
      new_miss = 1;
      e_valid = 0;
    end else if (stall) begin
      e_valid = 0;
    end else begin
      w = rd_word(m_pc);
      nxt = m_pc + 32'd4;
      pj = 0;
      if (predict_on) begin
        if (w[6:0] == 7'h6F) begin nxt = m_pc + j_off(w); pj = 1; end
        else if (w[6:0] == 7'h63 && bht[bi] >= 2) begin nxt = m_pc + b_off(w); pj = 1; end
      end
      m_lru[set] = 1 - hw;
      e_valid = 1; e_inst = w; e_ipc = m_pc; e_pred = pj;
      exp_q.push_back({pj, m_pc, w});
      new_issue = 1;
      m_pc = nxt;
    end
    if (predict_on && upd_valid) begin
      ub = int'((upd_pc >> 2) % 1024);
      if (upd_taken) begin if (bht[ub] < 3) bht[ub]++; end
      else begin if (bht[ub] > 0) bht[ub]--; end
    end
  endtask

  task automatic check_outputs();
    logic [64:0] ent;
    check_eq("inst_valid", inst_valid, e_valid);
    if (new_issue) begin
      ent = exp_q.pop_front();
      check_eq("inst", inst, ent[31:0]);
      check_eq("inst_pc", inst_pc, ent[63:32]);
      check_eq("pred_jump", pred_jump, ent[64]);
    end else begin
      check_eq("inst_hold", inst, e_inst);
      check_eq("inst_pc_hold", inst_pc, e_ipc);
      check_eq("pred_hold", pred_jump, e_pred);
    end
    check_eq("mem_req", mem_req, m_miss);
    check_eq("mem_addr", mem_addr, m_maddr);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    mem_valid = 0;
    mem_line = '0;
    if (rdy) begin
      if (mc_busy) begin
        if (mc_cnt == 0) begin
          mem_valid = 1;
          for (int k = 0; k < LW; k++) mem_line[k*32 +: 32] = rd_word(m_maddr + 32'(k * 4));
          mc_busy = 0;
        end else begin
          mc_cnt--;
        end
      end else if (force_spur || (spur_en && $urandom_range(0, 15) == 0)) begin
        mem_valid = 1;
        for (int k = 0; k < LW; k++) mem_line[k*32 +: 32] = $urandom();
      end
    end
    @(posedge clk);
    model_step();
    if (new_miss) begin mc_busy = 1; mc_cnt = mc_lat; end
    #1;
    check_outputs();
  endtask

  task automatic goto(input logic [31:0] a);
    redirect_valid = 1; redirect_pc = a;
    tick();
    redirect_valid = 0;
  endtask

  task automatic run_until_issue(output bit saw_req, output bit got);
    saw_req = 0; got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick();
      if (mem_req) saw_req = 1;
      if (inst_valid) got = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    mc_busy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_inst", inst, 0);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst_pc", inst_pc, 0);
    check_eq("rst_pred_jump", pred_jump, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit sr, g;
    logic [31:0] tmp;
    int r;
`ifdef ICACHE_PREDICT_EN
    predict_on = 1;
`else
    predict_on = 0;
`endif
    for (int i = 0; i < 1024; i++) begin
      tmp = $urandom();
      r = $urandom_range(0, 31);
      if (r < 4)       tmp[6:0] = 7'h63;
      else if (r == 4) tmp[6:0] = 7'h6F;
      else             tmp[6:0] = 7'h13;
      imem[i] = tmp;
    end
    for (int i = 0; i < 8; i++) imem[i] = 32'h0000_0013 + (i << 20);
    imem[2] = 32'h0400_00EF;   // JAL x1, +0x40 at 0x8
    imem[4] = 32'h0200_0063;   // BEQ +0x20 at 0x10

    spur_en = 0; force_spur = 0; mc_lat = 5;
    do_reset();

    // cold start: first refill of line 0, then sequential issue
    repeat (40) tick();

    // branch training at 0x10: three taken, then two not-taken
    upd_pc = 32'h10; upd_taken = 1; upd_valid = 1;
    repeat (3) tick();
    upd_valid = 0;
    goto(32'h10);
    repeat (12) tick();
    upd_pc = 32'h10; upd_taken = 0; upd_valid = 1;
    repeat (2) tick();
    upd_valid = 0;
    goto(32'h10);
    repeat (12) tick();

    // LRU replacement in set 0
    goto(32'h000); run_until_issue(sr, g); check_eq("issue_000", g, 1);
    goto(32'h400); run_until_issue(sr, g); check_eq("issue_400", g, 1);
    goto(32'h800); run_until_issue(sr, g); check_eq("issue_800", g, 1);
    goto(32'h400); run_until_issue(sr, g); check_eq("lru_hit_400", sr, 0);
    goto(32'h000); run_until_issue(sr, g); check_eq("lru_miss_000", sr, 1);

    // redirect while a refill is outstanding
    mc_lat = 10;
    goto(32'h100); tick(); tick();
    goto(32'h200);
    run_until_issue(sr, g);
    check_eq("redir_first_pc", inst_pc, 32'h200);
    goto(32'h100); run_until_issue(sr, g); check_eq("redir_line_filled", sr, 0);

    // global enable low: everything holds
    rdy = 0; repeat (3) tick(); rdy = 1;
    repeat (5) tick();

    // asynchronous reset in the middle of a refill
    mc_lat = 30;
    goto(32'h3000_0000); tick(); tick();
    check_eq("pre_rst_req", mem_req, 1);
    #2 rst_n = 0;
    #1;
    check_eq("rst_async_req", mem_req, 0);
    check_eq("rst_async_valid", inst_valid, 0);
    check_eq("rst_async_addr", mem_addr, 0);
    model_reset();
    mc_busy = 0;
    mem_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_valid = 0;
    rst_n = 1;
    mc_lat = 5;
    force_spur = 1; tick(); force_spur = 0;
    repeat (30) tick();
    goto(32'h3000_0000); run_until_issue(sr, g); check_eq("rst_line_invalid", sr, 1);

    // randomized traffic
    spur_en = 1;
    for (int i = 0; i < 2500; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 24) != 0);
      mc_lat = $urandom_range(0, 6);
      redirect_valid = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 3);
      if (r == 0)      redirect_pc = $urandom() & 32'hFFFF_FFFC;
      else             redirect_pc = 32'($urandom_range(0, 1023) * 4);
      upd_valid = ($urandom_range(0, 2) == 0);
      upd_pc = 32'($urandom_range(0, 63) * 4);
      upd_taken = $urandom_range(0, 1);
      tick();
    end
    redirect_valid = 0; upd_valid = 0; stall = 0; rdy = 1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
